// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB field layout and sync polarity values
// for the pixel output path. Defaults describe 640x480 @ 60 Hz.
package vga_pkg;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // A pixel occupies the low 12 bits of a FIFO word as R:G:B, 4 bits each
    localparam int PIX_W = 12;
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // Sync pulse polarity: the level driven while the pulse is asserted
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;
    localparam logic DEF_HS_POL       = SYNC_ACTIVE_LOW;
    localparam logic DEF_VS_POL       = SYNC_ACTIVE_LOW;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Splits the low pixel bits of a FIFO word into colour channels
    function automatic rgb_t unpack_pixel(input logic [PIX_W-1:0] word);
        rgb_t p;
        p.r = word[R_MSB:R_LSB];
        p.g = word[G_MSB:G_LSB];
        p.b = word[B_MSB:B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): a wrapping position counter
// with decoded active-region and sync-window flags. The wrap output is
// used to advance the next axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next position: clear has priority, otherwise advance and wrap at the end
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Position register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = (cnt_q < ACT_END);
    assign sync   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);
    assign wrap   = inc && (cnt_q == LAST);

endmodule

// File: rtl/vga_pixel_out.sv
// VGA raster generator and DAC output stage. Pops one show-ahead FIFO word
// per active pixel, registers sync/colour/de, and keeps a sticky flag for
// FIFO underflow during active video (the raster never stalls).
module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int   D_W      = 32,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = DEF_HS_POL,
    parameter logic VS_POL   = DEF_VS_POL
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [D_W-1:0] fifo_data,
    input  logic           fifo_empty,
    output logic           fifo_re,
    input  logic           underflow_clr,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [3:0]     r,
    output logic [3:0]     g,
    output logic [3:0]     b,
    output logic           frame_start,
    output logic           underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_active, h_sync, h_wrap;
    logic           v_active, v_sync, v_wrap;
    logic           active, hs_act, vs_act, pop;

    logic           de_q, de_d;
    rgb_t           rgb_q, rgb_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           frame_start_q, frame_start_d;
    logic           underflow_q, underflow_d;

    // Upper FIFO bits carry no pixel data; the vertical wrap is not needed
    logic           unused_bits;
    assign unused_bits = ^{fifo_data[D_W-1:PIX_W], v_wrap};

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .inc    (en),
        .clr    (!en),
        .cnt    (h_cnt),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .inc    (h_wrap),
        .clr    (!en),
        .cnt    (v_cnt),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    assign active  = en && h_active && v_active;
    assign hs_act  = en && h_sync;
    assign vs_act  = en && v_sync;
    assign pop     = active && !fifo_empty;
    assign fifo_re = pop;

    // Next values for the output stage; a starved active pixel goes out black
    always_comb begin
        de_d          = active;
        rgb_d         = pop ? unpack_pixel(fifo_data[PIX_W-1:0]) : '0;
        hsync_d       = hs_act ? HS_POL : ~HS_POL;
        vsync_d       = vs_act ? VS_POL : ~VS_POL;
        frame_start_d = en && (h_cnt == '0) && (v_cnt == '0);
        underflow_d   = (active && fifo_empty) || (underflow_q && !underflow_clr);
    end

    // Output register stage, lagging the raster counters by one clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q          <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign de          = de_q;
    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Self-checking bench for vga_pixel_out on a shrunken 14x7 raster, compared
// against a frame-position model that walks one linear pixel index.
module tb_vga_pixel_out;

    localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
    localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
    localparam int HT = H_A + H_F + H_S + H_B;
    localparam int VT = V_A + V_F + V_S + V_B;
    localparam int FRAME = HT * VT;
    localparam logic [16:0] RESET_OUT = {1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_re;
    logic        underflow_clr = 1'b0;
    logic        hsync, vsync, de, frame_start, underflow;
    logic [3:0]  r, g, b;

    int vectors = 0;
    int miscompares = 0;

    int          m_pos = 0;
    bit          m_uf = 0;
    bit          e_re, e_de, e_hs, e_vs, e_fs, e_uf;
    logic [11:0] e_rgb;

    vga_pixel_out #(
        .D_W(32), .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_re(fifo_re), .underflow_clr(underflow_clr),
        .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: x/y derived from a linear position within the frame
    task automatic model_cycle();
        int x, y;
        bit act;
        x = m_pos % HT;
        y = m_pos / HT;
        act   = en && (x < H_A) && (y < V_A);
        e_re  = act && !fifo_empty;
        e_de  = act;
        e_rgb = e_re ? fifo_data[11:0] : 12'h000;
        e_hs  = (en && x >= H_A + H_F && x < H_A + H_F + H_S) ? 1'b0 : 1'b1;
        e_vs  = (en && y >= V_A + V_F && y < V_A + V_F + V_S) ? 1'b0 : 1'b1;
        e_fs  = en && (m_pos == 0);
        m_uf  = (act && fifo_empty) || (m_uf && !underflow_clr);
        e_uf  = m_uf;
        m_pos = en ? (m_pos + 1) % FRAME : 0;
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_uf  = 0;
    endtask

    function automatic logic [16:0] dut_outs();
        return {de, r, g, b, hsync, vsync, frame_start, underflow};
    endfunction

    function automatic logic [16:0] exp_outs();
        return {e_de, e_rgb, e_hs, e_vs, e_fs, e_uf};
    endfunction

    task automatic drive(input bit e, input bit emp, input logic [31:0] d, input bit c);
        @(negedge clk);
        en = e;
        fifo_empty = emp;
        fifo_data = d;
        underflow_clr = c;
        model_cycle();
        #1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (dut_outs() !== RESET_OUT) begin
            miscompares++;
            $display("[TB] FAIL reset_outs: got %h expected %h", dut_outs(), RESET_OUT);
        end
        vectors++;
        if (fifo_re !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_re: got %b expected 0", fifo_re);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        int word = 0;
        int re_cnt = 0, de_cnt = 0, fs_cnt = 0, fs_first = -1, fs_second = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            drive(1'b1, 1'b0, word, 1'b0);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL stream_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            if (i < FRAME && fifo_re === 1'b1) re_cnt++;
            if (e_re) word++;
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL stream_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
            if (i < FRAME && de === 1'b1) de_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
            end
        end
        vectors++;
        if (re_cnt !== H_A * V_A) begin
            miscompares++;
            $display("[TB] FAIL stream_re_count: got %0d expected %0d", re_cnt, H_A * V_A);
        end
        vectors++;
        if (de_cnt !== H_A * V_A) begin
            miscompares++;
            $display("[TB] FAIL stream_de_count: got %0d expected %0d", de_cnt, H_A * V_A);
        end
        vectors++;
        if (fs_cnt !== 2 || fs_first !== 0 || fs_second - fs_first !== 98) begin
            miscompares++;
            $display("[TB] FAIL stream_frame_start: got count %0d first %0d second %0d expected 2/0/98",
                     fs_cnt, fs_first, fs_second);
        end
    endtask

    task automatic test_sync_timing();
        int hs_low = 0, vs_low = 0, hs_first = -1, vs_first = -1;
        for (int i = 0; i < FRAME; i++) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL sync_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL sync_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
            if (hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
        end
        vectors++;
        if (hs_first !== 10 || hs_low !== 14) begin
            miscompares++;
            $display("[TB] FAIL sync_h: got first %0d count %0d expected 10/14", hs_first, hs_low);
        end
        vectors++;
        if (vs_first !== 70 || vs_low !== 14) begin
            miscompares++;
            $display("[TB] FAIL sync_v: got first %0d count %0d expected 70/14", vs_first, vs_low);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i == 3, $urandom, i == 15);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL uf_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL uf_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
            if (i == 3) begin
                vectors++;
                if (de !== 1'b1 || {r, g, b} !== 12'h000 || underflow !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL uf_black: got de %b rgb %h uf %b expected 1/000/1", de, {r, g, b}, underflow);
                end
            end
            if (i == 14) begin
                vectors++;
                if (underflow !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL uf_sticky: got %b expected 1", underflow);
                end
            end
            if (i == 15) begin
                vectors++;
                if (underflow !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL uf_clear: got %b expected 0", underflow);
                end
            end
        end
    endtask

    task automatic test_clr_collision();
        // Position 20 is pixel 6 of line 1; 21 is pixel 7, still active
        while (m_pos != 20) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            settle();
        end
        drive(1'b1, 1'b1, $urandom, 1'b0);
        settle();
        drive(1'b1, 1'b1, $urandom, 1'b1);
        settle();
        vectors++;
        if (underflow !== 1'b1 || underflow !== e_uf) begin
            miscompares++;
            $display("[TB] FAIL clr_collision: got %b expected 1", underflow);
        end
        drive(1'b1, 1'b0, $urandom, 1'b1);
        settle();
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_after: got %b expected 0", underflow);
        end
    endtask

    task automatic test_en_drop();
        // Advance to h=5, v=2 with full per-cycle checking
        while (m_pos != 2 * HT + 5) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL drop_pre_outs: got %h expected %h", dut_outs(), exp_outs());
            end
        end
        drive(1'b0, 1'b0, $urandom, 1'b0);
        vectors++;
        if (fifo_re !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_re: got %b expected 0", fifo_re);
        end
        settle();
        vectors++;
        if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || {r, g, b} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL drop_outs: got de %b hs %b vs %b rgb %h expected 0/1/1/000",
                     de, hsync, vsync, {r, g, b});
        end
        repeat (3) begin
            drive(1'b0, 1'b0, $urandom, 1'b0);
            settle();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL reen_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL reen_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
            if (i == 0) begin
                vectors++;
                if (frame_start !== 1'b1 || de !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL reen_origin: got fs %b de %b expected 1/1", frame_start, de);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 9) == 0);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL rand_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL rand_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_async_reset();
        int word = 0;
        int re_cnt = 0;
        // Force a sticky underflow and an active pixel so reset has work to do
        drive(1'b1, 1'b1, $urandom, 1'b0);
        settle();
        drive(1'b1, 1'b0, $urandom, 1'b0);
        settle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        en = 1'b0;
        #1;
        vectors++;
        if (dut_outs() !== RESET_OUT) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_outs(), RESET_OUT);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < FRAME; i++) begin
            drive(1'b1, 1'b0, word, 1'b0);
            vectors++;
            if (fifo_re !== e_re) begin
                miscompares++;
                $display("[TB] FAIL post_reset_re cycle %0d: got %b expected %b", i, fifo_re, e_re);
            end
            if (fifo_re === 1'b1) re_cnt++;
            if (e_re) word++;
            settle();
            vectors++;
            if (dut_outs() !== exp_outs()) begin
                miscompares++;
                $display("[TB] FAIL post_reset_outs cycle %0d: got %h expected %h", i, dut_outs(), exp_outs());
            end
        end
        vectors++;
        if (re_cnt !== H_A * V_A) begin
            miscompares++;
            $display("[TB] FAIL post_reset_re_count: got %0d expected %0d", re_cnt, H_A * V_A);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_sync_timing();
        test_underflow();
        test_clr_collision();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
